mccomp_boot_ctrl: RTL and testbench
===================================

// Module: mccomp_boot_ctrl
// PURPOSE
//  Synthesizable program loader and register-dump controller for the multicycle computer.
//  Streams words into instruction/data memory and holds the core in reset while loading.
//  Releases core reset after a programmable hold.
//  Then scans reg_sel across the register file on request and returns each register
//  on a valid/ready stream.
// PARAMETERS
//  DATA_W    32   memory word / register width
//  ADDR_W    7    memory word-address width
//  DEPTH     128  loadable words (DEPTH <= 2**ADDR_W)
//  HOLD_CYC  2    cycles core_rstn stays low after last write (>=1)
//  NREG      32   registers scanned per dump
//  SEL_W     5    reg_sel width (NREG <= 2**SEL_W)
// PORTS
//  clk        in   1         system clock, rising edge
//  rstn       in   1         asynchronous active-low reset
//  load_start in   1         pulse: begin new program load
//  s_data     in   DATA_W    load stream word
//  s_valid    in   1         load stream valid
//  s_last     in   1         marks final word of program
//  s_ready    out  1         load stream ready
//  mem_we     out  1         memory write strobe
//  mem_addr   out  ADDR_W    memory word address
//  mem_wdata  out  DATA_W    memory write data
//  core_rstn  out  1         active-low reset to core
//  dump_req   in   1         pulse: dump register file
//  reg_sel    out  SEL_W     register index driven to core
//  reg_data   in   DATA_W    core register value, combinational from reg_sel
//  d_data     out  DATA_W    dumped register value
//  d_valid    out  1         dump stream valid
//  d_ready    in   1         dump stream ready
//  busy       out  1         high in LOAD/HOLD/DUMP
//  load_err   out  1         sticky: words beyond DEPTH dropped
//  word_cnt   out  ADDR_W+1  words written in current/last load
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0.
//   This includes core_rstn=0: the core is held in reset until the first load completes.
//  IDLE: core_rstn=0, s_ready=0. load_start -> LOAD.
//  LOAD entry: word_cnt=0, load_err=0, mem_addr=0.
//  LOAD: s_ready=1 (state-decoded, no full backpressure).
//   Beat accepted = s_valid&&s_ready.
//   Accepted beat with word_cnt<DEPTH: next cycle mem_we=1, mem_addr=word_cnt,
//    mem_wdata=s_data; word_cnt+1. Write latency is 1 cycle, one write per cycle.
//   Accepted beat with word_cnt==DEPTH: word dropped, no write, load_err=1.
//   Accepted beat with s_last=1 -> HOLD (this beat's write still issues).
//  HOLD: counts HOLD_CYC cycles, core_rstn=0, then -> RUN.
//  RUN: core_rstn=1.
//   load_start -> LOAD, and core_rstn=0 from the next cycle.
//   dump_req -> DUMP.
//   load_start and dump_req in the same cycle: load wins.
//  DUMP: core_rstn stays 1; reg_sel starts at 0.
//   Cycle after reg_sel settles: d_data=reg_data, d_valid=1.
//   Hold d_data/d_valid while !d_ready.
//   On d_valid&&d_ready: reg_sel+1, d_valid=0 for one settle cycle.
//   After handshake of index NREG-1: reg_sel=0 -> RUN.
//   load_start and dump_req are ignored in DUMP/LOAD/HOLD.
//   dump_req is ignored in IDLE.
//  mem_we is a single-cycle strobe and is 0 in every state except the cycle after a stored beat.
//  Async reset mid-operation: all outputs return to reset values immediately.
//   Memory contents are untouched; word_cnt is lost.
// TESTING
//  Load 4 words 0x20080005,0x20090007,0x01095020,0x0000000c (last on 4th)
//   -> mem_we at addr 0..3 with those data.
//   -> core_rstn rises exactly HOLD_CYC+1 cycles after the 4th write.
//   -> word_cnt=4, load_err=0.
//  s_valid gapped every other cycle during load -> writes only on accepted beats,
//   addresses contiguous 0..N-1.
//  DEPTH=4, stream 6 words, last on 6th -> 4 writes, load_err=1, word_cnt=4, reaches RUN.
//  In RUN, dump_req with reg 8=5, 9=7, 10=12 and d_ready toggling 1/0
//   -> 32 beats, indices in order, d_data[8]=5, d_data[10]=12, data stable while stalled.
//  load_start and dump_req in same RUN cycle -> LOAD entered, core_rstn=0 next cycle,
//   no d_valid.
//  rstn asserted during LOAD at word 2 -> outputs zero instantly.
//   Then new load_start reloads from addr 0.

Source files
------------

// File: rtl/mccomp_boot_ctrl.sv
// Program loader and register-dump controller for the multicycle computer.
// Streams a program into memory while the core is held in reset. Releases the
// core after a short hold. On request, walks reg_sel across the register file
// and returns every register on a valid/ready stream.
module mccomp_boot_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 128,
    parameter int HOLD_CYC = 2,
    parameter int NREG     = 32,
    parameter int SEL_W    = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rstn,
    input  logic              dump_req,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] d_data,
    output logic              d_valid,
    input  logic              d_ready,
    output logic              busy,
    output logic              load_err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DUMP
    } state_t;

    localparam int HC_W = $clog2(HOLD_CYC + 1) + 1;
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NREG - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              load_err_q, load_err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              d_valid_q, d_valid_d;
    logic              beat;

    // Loading is accepted in every LOAD cycle; there is no backpressure.
    assign s_ready = (state_q == ST_LOAD);
    assign beat    = s_valid && s_ready;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            load_err_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_cnt_q  <= '0;
            reg_sel_q   <= '0;
            d_data_q    <= '0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            load_err_q  <= load_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_cnt_q  <= hold_cnt_d;
            reg_sel_q   <= reg_sel_d;
            d_data_q    <= d_data_d;
            d_valid_q   <= d_valid_d;
        end
    end

    // Next-state and datapath decisions; the write strobe defaults low so it is a
    // single-cycle pulse following each stored beat.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        load_err_d  = load_err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_cnt_d  = hold_cnt_q;
        reg_sel_d   = reg_sel_q;
        d_data_d    = d_data_q;
        d_valid_d   = d_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                    mem_addr_d = '0;
                end
            end

            ST_LOAD: begin
                if (beat) begin
                    if (word_cnt_q < DEPTH_CNT) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = s_data;
                        word_cnt_d  = word_cnt_q + (ADDR_W + 1)'(1);
                    end else begin
                        // Memory is full: the word is dropped and flagged.
                        load_err_d = 1'b1;
                    end
                    if (s_last) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end

            ST_HOLD: begin
                // The first HOLD cycle is the final write cycle, so HOLD lasts
                // HOLD_CYC+1 cycles to keep the core low HOLD_CYC cycles after it.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end

            ST_RUN: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                    mem_addr_d = '0;
                end else if (dump_req) begin
                    state_d   = ST_DUMP;
                    reg_sel_d = '0;
                    d_valid_d = 1'b0;
                end
            end

            ST_DUMP: begin
                if (!d_valid_q) begin
                    // reg_sel has had a full cycle to settle; capture the register.
                    d_valid_d = 1'b1;
                    d_data_d  = reg_data;
                end else if (d_ready) begin
                    d_valid_d = 1'b0;
                    if (reg_sel_q == SEL_LAST) begin
                        reg_sel_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        reg_sel_d = reg_sel_q + SEL_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign word_cnt  = word_cnt_q;
    assign load_err  = load_err_q;
    assign reg_sel   = reg_sel_q;
    assign d_data    = d_data_q;
    assign d_valid   = d_valid_q;
    assign core_rstn = (state_q == ST_RUN) || (state_q == ST_DUMP);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_DUMP);

endmodule

// File: tb/tb_mccomp_boot_ctrl.sv
// Scoreboard bench for mccomp_boot_ctrl: stimulus pushes expected memory writes
// and dump beats into queues, a negedge monitor pops and compares them.
module tb_mccomp_boot_ctrl;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 7;
    localparam int DEPTH    = 4;
    localparam int HOLD_CYC = 2;
    localparam int NREG     = 32;
    localparam int SEL_W    = 5;

    logic              clk = 1'b0;
    logic              rstn;
    logic              load_start;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_rstn;
    logic              dump_req;
    logic [SEL_W-1:0]  reg_sel;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] d_data;
    logic              d_valid;
    logic              d_ready;
    logic              busy;
    logic              load_err;
    logic [ADDR_W:0]   word_cnt;

    // Core register file model, read combinationally through reg_sel.
    logic [DATA_W-1:0] regs [NREG];
    assign reg_data = regs[reg_sel];

    always #5 clk = ~clk;

    mccomp_boot_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .HOLD_CYC(HOLD_CYC), .NREG(NREG), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rstn(rstn), .load_start(load_start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rstn(core_rstn), .dump_req(dump_req), .reg_sel(reg_sel),
        .reg_data(reg_data), .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
        .busy(busy), .load_err(load_err), .word_cnt(word_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wq_addr [$];
    logic [DATA_W-1:0] wq_data [$];
    int                dq_idx  [$];
    logic [DATA_W-1:0] dq_data [$];
    logic [DATA_W-1:0] load_words [$];

    bit                stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every write and every dump handshake against the queues.
    always @(negedge clk) begin
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("dump_stall_valid", d_valid, 1'b1);
                chk("dump_stall_data", d_data, stall_data);
            end
            stall_prev = d_valid && !d_ready;
            stall_data = d_data;
            if (mem_we) begin
                if (wq_addr.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    $display("WR   addr=%0d data=%08h", mem_addr, mem_wdata);
                    chk("write_addr", mem_addr, wq_addr.pop_front());
                    chk("write_data", mem_wdata, wq_data.pop_front());
                end
            end
            if (d_valid && d_ready) begin
                if (dq_idx.size() == 0) begin
                    chk("unexpected_dump_beat", 1'b1, 1'b0);
                end else begin
                    $display("DUMP idx=%0d data=%08h", reg_sel, d_data);
                    chk("dump_index", reg_sel, dq_idx.pop_front());
                    chk("dump_data", d_data, dq_data.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, "_ctrl"}, {s_ready, mem_we, mem_addr, core_rstn, reg_sel,
                              d_valid, busy, load_err, word_cnt}, 64'd0);
        chk({name, "_data"}, {mem_wdata, d_data}, 64'd0);
    endtask

    // Loads load_words; gap_mode 0 = back-to-back, 1 = every other cycle, 2 = random.
    task automatic do_load(input int gap_mode, input bit with_dump);
        int n = load_words.size();
        int k = 0;
        load_start = 1'b1;
        dump_req   = with_dump;
        tick();
        load_start = 1'b0;
        dump_req   = 1'b0;
        chk("load_core_rstn_low", core_rstn, 1'b0);
        chk("load_entry", {busy, s_ready, load_err, word_cnt}, {1'b1, 1'b1, 1'b0, 8'd0});
        for (int i = 0; i < n; i++) begin
            int gaps = (gap_mode == 1 && i > 0) ? 1 :
                       (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'b1;
                tick();
            end
            s_valid = 1'b1;
            s_data  = load_words[i];
            s_last  = (i == n - 1);
            if (i < DEPTH) begin
                wq_addr.push_back(ADDR_W'(i));
                wq_data.push_back(load_words[i]);
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
        while (!core_rstn && k < 20) begin
            tick();
            k++;
        end
        chk("core_rstn_rise_delay", k, HOLD_CYC + 1);
        chk("load_word_cnt", word_cnt, (n < DEPTH) ? n : DEPTH);
        chk("load_err", load_err, n > DEPTH);
        chk("run_not_busy", busy, 1'b0);
        chk("writes_drained", wq_addr.size(), 0);
        $display("LOAD words=%0d gap_mode=%0d word_cnt=%0d load_err=%0d", n, gap_mode, word_cnt, load_err);
    endtask

    // Dumps the register file; ready_mode 0 = toggle 1/0, 1 = random.
    task automatic do_dump(input int ready_mode);
        int cyc = 0;
        bit r = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            dq_idx.push_back(i);
            dq_data.push_back(regs[i]);
        end
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        chk("dump_entry", {busy, core_rstn}, 2'b11);
        while (dq_idx.size() != 0 && cyc < 2000) begin
            d_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : r;
            r = ~r;
            tick();
            cyc++;
        end
        d_ready = 1'b0;
        chk("dump_drained", dq_idx.size(), 0);
        chk("dump_exit", {busy, d_valid, core_rstn, reg_sel}, {3'b001, 5'd0});
        dq_idx.delete();
        dq_data.delete();
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    endtask

    initial begin
        rstn = 1'b0;
        load_start = 1'b0;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        dump_req = 1'b0;
        d_ready = 1'b0;
        randomize_regs();
        #23;
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        // dump_req in IDLE is ignored
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        chk("idle_dump_ignored", {busy, d_valid, core_rstn}, 3'b000);

        load_words = {32'h20080005, 32'h20090007, 32'h01095020, 32'h0000000c};
        do_load(0, 1'b0);

        load_words = {$urandom, $urandom, $urandom, $urandom};
        do_load(1, 1'b0);

        load_words = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_load(0, 1'b0);

        randomize_regs();
        regs[8] = 32'd5;
        regs[9] = 32'd7;
        regs[10] = 32'd12;
        do_dump(0);

        // load_start and dump_req together: load wins, no dump beats expected
        load_words = {$urandom, $urandom, $urandom};
        do_load(0, 1'b1);

        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 6);
            load_words.delete();
            for (int i = 0; i < n; i++) load_words.push_back($urandom);
            do_load(2, 1'b0);
            randomize_regs();
            do_dump(1);
        end

        // Reset asserted during a load, at word 2
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data = $urandom;
            s_last = 1'b0;
            wq_addr.push_back(ADDR_W'(i));
            wq_data.push_back(s_data);
            tick();
        end
        s_data = 32'hdead0002;
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_all_zero("midload_reset");
        chk("midload_writes_done", wq_addr.size(), 0);
        s_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        tick();
        load_words = {32'h20080005, 32'h20090007, 32'h01095020, 32'h0000000c};
        do_load(0, 1'b0);
        randomize_regs();
        do_dump(0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
